// File: rtl/branch_pkg.sv
// branch_pkg: shared branch/jump encodings and redirect FSM states
package branch_pkg;
  typedef enum logic [2:0] {
    BOP_NONE = 3'd0,
    BOP_BEQ  = 3'd1,
    BOP_BNE  = 3'd2,
    BOP_BLEZ = 3'd3,
    BOP_BGTZ = 3'd4,
    BOP_BLTZ = 3'd5,
    BOP_BGEZ = 3'd6
  } bop_e;
  typedef enum logic [1:0] {
    JUMP_NONE = 2'd0,
    JUMP_J    = 2'd1,
    JUMP_JR   = 2'd2
  } jump_e;
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } rc_state_e;
endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: combinational branch condition, jr alignment check and target computation
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [1:0]  jump,
  input  logic [2:0]  bop,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] pc4,
  input  logic [15:0] imm16,
  input  logic [25:0] index26,
  output logic        taken,
  output logic        addr_err,
  output logic [31:0] target
);
  logic eq, neg, zero, cond, is_j, is_jr;
  always_comb begin
    eq       = rs_val == rt_val;
    neg      = rs_val[31];
    zero     = rs_val == '0;
    is_j     = jump == JUMP_J;
    is_jr    = jump == JUMP_JR;
    cond     = bop == BOP_BEQ  ? eq :
               bop == BOP_BNE  ? ~eq :
               bop == BOP_BLEZ ? neg | zero :
               bop == BOP_BGTZ ? ~neg & ~zero :
               bop == BOP_BLTZ ? neg :
               bop == BOP_BGEZ ? ~neg : 1'b0;
    addr_err = is_jr & (rs_val[1:0] != 2'b00);
    taken    = is_j | (is_jr & ~addr_err) | (~is_j & ~is_jr & cond);
    target   = is_j  ? {pc4[31:28], index26, 2'b00} :
               is_jr ? rs_val :
                       pc4 + {{14{imm16[15]}}, imm16, 2'b00};
  end
endmodule

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: decode-stage branch resolution, fetch redirect handshake and perf counters
module branch_redirect_ctrl
  import branch_pkg::*;
#(
  parameter int DELAY_SLOT = 1,
  parameter int CNT_W      = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_dec_valid,
  input  logic [1:0]       i_jump,
  input  logic [2:0]       i_bop,
  input  logic [31:0]      i_rs_val,
  input  logic [31:0]      i_rt_val,
  input  logic [31:0]      i_pc4,
  input  logic [15:0]      i_imm16,
  input  logic [25:0]      i_index26,
  input  logic             i_opnd_hazard,
  input  logic             i_fetch_ready,
  input  logic             i_flush_x,
  output logic             o_redirect,
  output logic [31:0]      o_target,
  output logic             o_flush_f,
  output logic             o_stall_d,
  output logic             o_addr_err,
  output logic [CNT_W-1:0] o_br_cnt,
  output logic [CNT_W-1:0] o_taken_cnt,
  output logic [CNT_W-1:0] o_stall_cnt
);
  rc_state_e   state, state_n;
  logic [31:0] held_t, held_n, target;
  logic        taken, addr_err, cti, live, idle, resolve, take, redir;
  branch_cond_eval u_eval (
    .jump    (i_jump),
    .bop     (i_bop),
    .rs_val  (i_rs_val),
    .rt_val  (i_rt_val),
    .pc4     (i_pc4),
    .imm16   (i_imm16),
    .index26 (i_index26),
    .taken   (taken),
    .addr_err(addr_err),
    .target  (target)
  );
  always_comb begin
    cti         = i_dec_valid & (i_jump != 2'b00 | i_bop != 3'b000);
    live        = ~i_rst & ~i_flush_x;
    idle        = state == IDLE;
    resolve     = live & cti & ~i_opnd_hazard & idle;
    take        = resolve & taken;
    redir       = take | (live & ~idle);
    o_redirect  = redir;
    o_target    = idle ? target : held_t;
    o_stall_d   = live & ((cti & i_opnd_hazard & idle) | (take & ~i_fetch_ready) | (~idle & ~i_fetch_ready));
    o_addr_err  = resolve & addr_err;
    o_flush_f   = DELAY_SLOT == 0 ? redir & i_fetch_ready : 1'b0;
    state_n     = ~live ? IDLE :
                  idle  ? (take & ~i_fetch_ready ? HOLD : IDLE) :
                          (i_fetch_ready ? IDLE : HOLD);
    held_n      = ~live ? '0 : (idle & take & ~i_fetch_ready) ? target : held_t;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      held_t      <= '0;
      o_br_cnt    <= '0;
      o_taken_cnt <= '0;
      o_stall_cnt <= '0;
    end else begin
      state       <= state_n;
      held_t      <= held_n;
      o_br_cnt    <= o_br_cnt + CNT_W'(resolve);
      o_taken_cnt <= o_taken_cnt + CNT_W'(take);
      o_stall_cnt <= o_stall_cnt + CNT_W'(o_stall_d);
    end
  end
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: directed and random checks of both delay-slot variants against a cycle model
module tb_branch_redirect_ctrl;
  logic        clk = 1'b0;
  logic        rst, dv, haz, rdy, fx;
  logic [1:0]  jump;
  logic [2:0]  bop;
  logic [31:0] rs, rt, pc4;
  logic [15:0] imm;
  logic [25:0] idx;
  logic        red1, ff1, st1, ae1, red0, ff0, st0, ae0;
  logic [31:0] tg1, tg0, br1, tk1, sc1, br0, tk0, sc0;
  int          total = 0, bad = 0;
  bit          m_hold = 0;
  logic [31:0] m_ht = '0, m_br = '0, m_tk = '0, m_st = '0;
  always #5 clk = ~clk;
  branch_redirect_ctrl #(.DELAY_SLOT(1), .CNT_W(32)) u_ds1 (
    .i_clk(clk), .i_rst(rst), .i_dec_valid(dv), .i_jump(jump), .i_bop(bop),
    .i_rs_val(rs), .i_rt_val(rt), .i_pc4(pc4), .i_imm16(imm), .i_index26(idx),
    .i_opnd_hazard(haz), .i_fetch_ready(rdy), .i_flush_x(fx),
    .o_redirect(red1), .o_target(tg1), .o_flush_f(ff1), .o_stall_d(st1), .o_addr_err(ae1),
    .o_br_cnt(br1), .o_taken_cnt(tk1), .o_stall_cnt(sc1)
  );
  branch_redirect_ctrl #(.DELAY_SLOT(0), .CNT_W(32)) u_ds0 (
    .i_clk(clk), .i_rst(rst), .i_dec_valid(dv), .i_jump(jump), .i_bop(bop),
    .i_rs_val(rs), .i_rt_val(rt), .i_pc4(pc4), .i_imm16(imm), .i_index26(idx),
    .i_opnd_hazard(haz), .i_fetch_ready(rdy), .i_flush_x(fx),
    .o_redirect(red0), .o_target(tg0), .o_flush_f(ff0), .o_stall_d(st0), .o_addr_err(ae0),
    .o_br_cnt(br0), .o_taken_cnt(tk0), .o_stall_cnt(sc0)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic void model_eval(output bit tk, output bit err, output logic [31:0] tgt);
    logic signed [31:0] off, srs;
    off = $signed(imm);
    srs = $signed(rs);
    tk  = 0;
    err = 0;
    if (jump == 2'd1) begin
      tk  = 1;
      tgt = (pc4 & 32'hF000_0000) + {6'b0, idx} * 4;
    end else if (jump == 2'd2) begin
      err = (rs % 4) != 0;
      tk  = !err;
      tgt = rs;
    end else begin
      tgt = pc4 + off * 4;
      case (bop)
        3'd1: tk = rs == rt;
        3'd2: tk = rs != rt;
        3'd3: tk = srs <= 0;
        3'd4: tk = srs > 0;
        3'd5: tk = srs < 0;
        3'd6: tk = srs >= 0;
        default: tk = 0;
      endcase
    end
  endfunction
  task automatic set(input bit v, input logic [1:0] j, input logic [2:0] b, input logic [31:0] a,
                     input logic [31:0] c, input logic [31:0] p, input logic [15:0] i,
                     input logic [25:0] x, input bit h, input bit r);
    dv = v; jump = j; bop = b; rs = a; rt = c; pc4 = p; imm = i; idx = x; haz = h; rdy = r;
    fx = 0; rst = 0;
  endtask
  task automatic step();
    bit tk, err, cti, res, e_red, e_stall, e_err, nh;
    logic [31:0] ctgt, e_tgt;
    model_eval(tk, err, ctgt);
    cti = dv && (jump != 0 || bop != 0);
    res = 0; e_red = 0; e_stall = 0; e_err = 0; nh = 0; e_tgt = ctgt;
    if (rst || fx) nh = 0;
    else if (m_hold) begin
      e_red = 1; e_tgt = m_ht; e_stall = !rdy; nh = !rdy;
    end else begin
      res = cti && !haz;
      e_red = res && tk;
      e_err = res && err;
      e_stall = (cti && haz) || (e_red && !rdy);
      nh = e_red && !rdy;
    end
    @(negedge clk);
    chk("redirect", 32'(red1), 32'(e_red));
    chk("redirect_ds0", 32'(red0), 32'(e_red));
    if (e_red) begin
      chk("target", tg1, e_tgt);
      chk("target_ds0", tg0, e_tgt);
    end
    chk("stall_d", 32'(st1), 32'(e_stall));
    chk("stall_d_ds0", 32'(st0), 32'(e_stall));
    chk("addr_err", 32'(ae1), 32'(e_err));
    chk("addr_err_ds0", 32'(ae0), 32'(e_err));
    chk("flush_f_ds1", 32'(ff1), 32'd0);
    chk("flush_f_ds0", 32'(ff0), 32'(e_red && rdy));
    chk("br_cnt", br1, m_br);
    chk("taken_cnt", tk1, m_tk);
    chk("stall_cnt", sc1, m_st);
    chk("br_cnt_ds0", br0, m_br);
    chk("stall_cnt_ds0", sc0, m_st);
    if (rst) begin
      m_hold = 0; m_ht = '0; m_br = '0; m_tk = '0; m_st = '0;
    end else begin
      if (!m_hold && nh) m_ht = ctgt;
      m_hold = nh;
      m_br += 32'(res);
      m_tk += 32'(res && tk);
      m_st += 32'(e_stall);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    set(1, 2'd0, 3'd1, 32'd5, 32'd5, 32'h0040_0010, 16'h0003, 26'd0, 0, 1);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 1;
    step();
    set(1, 2'd0, 3'd1, 32'd5, 32'd5, 32'h0040_0010, 16'h0003, 26'd0, 0, 1);
    step();
    set(0, 2'd0, 3'd0, 32'd0, 32'd0, 32'h0040_0014, 16'h0000, 26'd0, 0, 1);
    step();
    chk("beq_br_cnt_1", br1, 32'd1);
    chk("beq_taken_cnt_1", tk1, 32'd1);
    set(1, 2'd0, 3'd4, 32'hFFFF_FFFF, 32'd0, 32'h0000_2000, 16'h0010, 26'd0, 0, 1);
    step();
    set(1, 2'd0, 3'd5, 32'hFFFF_FFFF, 32'd0, 32'h0000_2000, 16'h0010, 26'd0, 0, 1);
    step();
    set(1, 2'd2, 3'd0, 32'h0000_1002, 32'd0, 32'h0000_3000, 16'h0000, 26'd0, 0, 1);
    step();
    set(1, 2'd2, 3'd0, 32'h0000_1000, 32'd0, 32'h0000_3000, 16'h0000, 26'd0, 0, 1);
    step();
    set(0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 16'h0000, 26'd0, 0, 1);
    step();
    for (int i = 0; i < 4; i++) begin
      set(1, 2'd1, 3'd0, 32'd0, 32'd0, 32'h1000_0008, 16'h0000, 26'h0000040, 0, i == 3);
      step();
    end
    set(0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 16'h0000, 26'd0, 0, 1);
    step();
    chk("j_stall_cnt_3", sc1, 32'd3);
    for (int i = 0; i < 3; i++) begin
      set(1, 2'd0, 3'd2, 32'd7, 32'd9, 32'h0000_4000, 16'hFFFE, 26'd0, i < 2, 0);
      step();
    end
    set(1, 2'd0, 3'd2, 32'd7, 32'd9, 32'h0000_4000, 16'hFFFE, 26'd0, 0, 1);
    fx = 1;
    step();
    set(0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 16'h0000, 26'd0, 0, 1);
    step();
    set(1, 2'd0, 3'd6, 32'd0, 32'd0, 32'h0000_5000, 16'h0004, 26'd0, 0, 0);
    step();
    set(1, 2'd0, 3'd6, 32'd0, 32'd0, 32'h0000_5000, 16'h0004, 26'd0, 0, 0);
    rst = 1;
    step();
    set(0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 16'h0000, 26'd0, 0, 1);
    step();
    set(1, 2'd0, 3'd1, 32'd3, 32'd3, 32'hFFFF_FFFC, 16'h0001, 26'd0, 0, 1);
    step();
    set(1, 2'd0, 3'd7, 32'd3, 32'd3, 32'h0000_0100, 16'h0001, 26'd0, 0, 1);
    step();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, c;
      logic [1:0]  j;
      logic [2:0]  b;
      case ($urandom_range(0, 4))
        0: a = 32'd0;
        1: a = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        default: a = $urandom;
      endcase
      c = ($urandom_range(0, 2) == 0) ? a : $urandom;
      j = 2'($urandom_range(0, 2));
      b = (j == 0 || $urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      set($urandom_range(0, 3) != 0, j, b, a, c, $urandom, 16'($urandom), 26'($urandom),
          $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
      fx  = $urandom_range(0, 19) == 0;
      rst = $urandom_range(0, 49) == 0;
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
